// File: rtl/alu8.sv
// 8-bit registered ALU for the Octa16 datapath: add/sub, nor/nand, set-less-than,
// logical/arithmetic shifts; result and signed overflow are captured one cycle later.
module alu8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rs1,
  input  logic [7:0] rs2,
  input  logic [2:0] ctrl,
  input  logic       flag,
  output logic [7:0] out,
  output logic       overflow
);

  localparam logic [2:0] OP_ADDSUB = 3'b000;
  localparam logic [2:0] OP_LOGIC  = 3'b001;
  localparam logic [2:0] OP_SLT    = 3'b010;
  localparam logic [2:0] OP_SHIFT  = 3'b011;
  localparam logic [2:0] OP_SRA    = 3'b100;

  logic [7:0] w_sum;
  logic [7:0] w_diff;
  logic [2:0] w_shamt;
  logic [7:0] w_result;
  logic       w_ovf;
  logic [7:0] r_out;
  logic       r_ovf;

  assign w_sum   = rs1 + rs2;
  assign w_diff  = rs1 - rs2;
  assign w_shamt = rs2[2:0];

  // Next-state result and overflow for the selected operation.
  always_comb begin
    w_result = 8'h00;
    w_ovf    = 1'b0;
    case (ctrl)
      OP_ADDSUB: begin
        if (flag) begin
          w_result = w_diff;
          w_ovf    = (rs1[7] != rs2[7]) && (w_diff[7] != rs1[7]);
        end else begin
          w_result = w_sum;
          w_ovf    = (rs1[7] == rs2[7]) && (w_sum[7] != rs1[7]);
        end
      end
      OP_LOGIC: begin
        if (flag) begin
          w_result = ~(rs1 & rs2);
        end else begin
          w_result = ~(rs1 | rs2);
        end
      end
      OP_SLT: begin
        if (flag) begin
          w_result = ($signed(rs1) < $signed(rs2)) ? 8'h01 : 8'h00;
        end else begin
          w_result = (rs1 < rs2) ? 8'h01 : 8'h00;
        end
      end
      OP_SHIFT: begin
        if (flag) begin
          w_result = rs1 << w_shamt;
        end else begin
          w_result = rs1 >> w_shamt;
        end
      end
      OP_SRA: begin
        w_result = $unsigned($signed(rs1) >>> w_shamt);
      end
      default: begin
        w_result = 8'h00;
        w_ovf    = 1'b0;
      end
    endcase
  end

  // Output registers; reset discards whatever operation is sampled on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= 8'h00;
      r_ovf <= 1'b0;
    end else begin
      r_out <= w_result;
      r_ovf <= w_ovf;
    end
  end

  assign out      = r_out;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_alu8.sv
// Self-checking bench for alu8: directed vectors plus a randomized stream
// compared against an integer-arithmetic reference model.
module tb_alu8;

  logic       clk;
  logic       rst;
  logic [7:0] rs1;
  logic [7:0] rs2;
  logic [2:0] ctrl;
  logic       flag;
  logic [7:0] out;
  logic       overflow;

  int checks;
  int failures;

  alu8 dut (
    .clk      (clk),
    .rst      (rst),
    .rs1      (rs1),
    .rs2      (rs2),
    .ctrl     (ctrl),
    .flag     (flag),
    .out      (out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {overflow, out} compared as one 9-bit value
  task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got ov=%0b out=%02h, expected ov=%0b out=%02h",
               tag, got[8], got[7:0], exp[8], exp[7:0]);
    end
  endtask

  // Reference model in plain integer arithmetic
  function automatic logic [8:0] ref_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] c, input logic f);
    int sa, sb, ua, ub, n, r;
    logic [7:0] res;
    logic ov;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    n  = ub % 8;
    ov = 1'b0;
    res = 8'h00;
    case (c)
      3'd0: begin
        r   = f ? (sa - sb) : (sa + sb);
        ov  = (r > 127) || (r < -128);
        res = 8'((r % 256 + 256) % 256);
      end
      3'd1: begin
        r   = f ? (255 - (ua & ub)) : (255 - (ua | ub));
        res = 8'(r);
      end
      3'd2: res = (f ? (sa < sb) : (ua < ub)) ? 8'h01 : 8'h00;
      3'd3: res = f ? 8'((ua * (1 << n)) % 256) : 8'(ua / (1 << n));
      3'd4: begin
        r   = sa >>> n;
        res = 8'((r % 256 + 256) % 256);
      end
      default: res = 8'h00;
    endcase
    return {ov, res};
  endfunction

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] c, input logic f, input logic [8:0] exp);
    rs1 = a; rs2 = b; ctrl = c; flag = f;
    @(posedge clk);
    #1;
    check_eq(tag, {overflow, out}, exp);
    check_eq({tag, "_ref"}, {overflow, out}, ref_model(a, b, c, f));
  endtask

  initial begin
    logic [8:0] exp;
    logic       do_rst;
    checks   = 0;
    failures = 0;

    rst = 1'b1; rs1 = 8'hFF; rs2 = 8'hFF; ctrl = 3'b000; flag = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_eq("reset", {overflow, out}, 9'h000);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("first_after_reset", {overflow, out}, {1'b0, 8'hFE});

    run_op("add_small", 8'h0F, 8'h0A, 3'b000, 1'b0, {1'b0, 8'h19});
    run_op("add_ovf",   8'h82, 8'h82, 3'b000, 1'b0, {1'b1, 8'h04});
    run_op("sub_pos",   8'h0F, 8'h0A, 3'b000, 1'b1, {1'b0, 8'h05});
    run_op("sub_neg",   8'h0A, 8'h0F, 3'b000, 1'b1, {1'b0, 8'hFB});
    run_op("sub_ovf",   8'h80, 8'h01, 3'b000, 1'b1, {1'b1, 8'h7F});
    run_op("nor",       8'hAA, 8'hCC, 3'b001, 1'b0, {1'b0, 8'h11});
    run_op("nand",      8'hAA, 8'hCC, 3'b001, 1'b1, {1'b0, 8'h77});
    run_op("sltu_lt",   8'h0A, 8'h14, 3'b010, 1'b0, {1'b0, 8'h01});
    run_op("sltu_ge",   8'h1E, 8'h14, 3'b010, 1'b0, {1'b0, 8'h00});
    run_op("sltu_big",  8'h80, 8'h01, 3'b010, 1'b0, {1'b0, 8'h00});
    run_op("slt_neg",   8'h80, 8'h01, 3'b010, 1'b1, {1'b0, 8'h01});
    run_op("sll",       8'h0F, 8'h02, 3'b011, 1'b1, {1'b0, 8'h3C});
    run_op("srl",       8'hF0, 8'h02, 3'b011, 1'b0, {1'b0, 8'h3C});
    run_op("sra_neg",   8'hF0, 8'h02, 3'b100, 1'b0, {1'b0, 8'hFC});
    run_op("sra_pos",   8'h70, 8'h02, 3'b100, 1'b1, {1'b0, 8'h1C});
    run_op("sll_mask",  8'h0F, 8'h0A, 3'b011, 1'b1, {1'b0, 8'h3C});
    run_op("srl_mask",  8'hF0, 8'h0A, 3'b011, 1'b0, {1'b0, 8'h3C});
    run_op("sra_mask",  8'hF0, 8'h0A, 3'b100, 1'b0, {1'b0, 8'hFC});
    run_op("sra_mask2", 8'h70, 8'h0A, 3'b100, 1'b0, {1'b0, 8'h1C});
    run_op("shift_zero", 8'hA5, 8'hF8, 3'b011, 1'b0, {1'b0, 8'hA5});
    run_op("rsvd_101",  8'hFF, 8'h7F, 3'b101, 1'b1, {1'b0, 8'h00});
    run_op("rsvd_110",  8'h80, 8'h80, 3'b110, 1'b0, {1'b0, 8'h00});
    run_op("rsvd_111",  8'h7F, 8'h01, 3'b111, 1'b1, {1'b0, 8'h00});

    // Back-to-back random stream with occasional mid-stream reset
    for (int i = 0; i < 400; i++) begin
      do_rst = ($urandom_range(0, 15) == 0);
      rst  = do_rst;
      rs1  = 8'($urandom);
      rs2  = 8'($urandom);
      ctrl = 3'($urandom);
      flag = 1'($urandom);
      exp  = do_rst ? 9'h000 : ref_model(rs1, rs2, ctrl, flag);
      @(posedge clk);
      #1;
      check_eq(do_rst ? "rand_rst" : "rand", {overflow, out}, exp);
      rst  = 1'b0;
      rs1  = ~rs1;
      rs2  = rs2 + 8'h01;
      ctrl = ctrl + 3'd1;
      #2;
      check_eq("hold", {overflow, out}, exp);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
